lcd_sequencer: RTL and testbench

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

---
 rtl/lcd_pkg.sv | 43 ++++
 rtl/lcd_step_timer.sv | 32 +++
 rtl/lcd_sequencer.sv | 138 +++++++++++++
 tb/tb_lcd_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - sequencer states, LCD command bytes and display mode codes
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_DELAY,
    ST_FUNC_SET,
    ST_DISP_ON,
    ST_ENTRY,
    ST_CLEAR,
    ST_CLR_WAIT,
    ST_LINE1,
    ST_WRITE,
    ST_IDLE
  } state_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;

  localparam logic [1:0] MODE_WATCH     = 2'b00;
  localparam logic [1:0] MODE_ALARM     = 2'b01;
  localparam logic [1:0] MODE_STOPWATCH = 2'b10;
  localparam logic [1:0] MODE_SETTING   = 2'b11;

  // States that drive a timed bus transfer with an enable strobe.
  function automatic logic is_xfer(state_e st);
    return st inside {ST_FUNC_SET, ST_DISP_ON, ST_ENTRY, ST_CLEAR, ST_LINE1, ST_WRITE};
  endfunction

  function automatic logic [7:0] cmd_byte(state_e st);
    case (st)
      ST_FUNC_SET: return CMD_FUNC_SET;
      ST_DISP_ON:  return CMD_DISP_ON;
      ST_ENTRY:    return CMD_ENTRY;
      ST_CLEAR:    return CMD_CLEAR;
      ST_LINE1:    return CMD_LINE1;
      default:     return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lcd_step_timer.sv
// rtl/lcd_step_timer.sv - per-transfer step counter, end-of-step pulse and enable window
module lcd_step_timer #(
  parameter int STEP_CYC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic end_step,
  output logic e_win
);

  localparam int SW = $clog2(STEP_CYC);
  localparam logic [SW-1:0] S_LAST = SW'(STEP_CYC - 1);
  localparam logic [SW-1:0] S_HALF = SW'(STEP_CYC / 2);

  logic [SW-1:0] s_q, s_d;

  // Held at zero while idle so every transfer starts from s = 0.
  always_comb begin
    s_d = '0;
    if (en && (s_q != S_LAST)) s_d = s_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_q <= '0;
    else      s_q <= s_d;
  end

  assign end_step = en && (s_q == S_LAST);
  assign e_win    = en && (s_q != '0) && (s_q <= S_HALF);

endmodule

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - HD44780-style init sequence and single-line refresh engine
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int STEP_CYC  = 100,
  parameter int POWER_CYC = 20000,
  parameter int CLEAR_CYC = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       refresh,
  input  logic [7:0] char_data,
  output logic [1:0] mode_sel,
  output logic [3:0] cnt,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db,
  output logic       busy,
  output logic       done
);

  localparam int DLY_MAX = (POWER_CYC > CLEAR_CYC) ? POWER_CYC : CLEAR_CYC;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam logic [DLY_W-1:0] DLY_ONE    = DLY_W'(1);
  localparam logic [DLY_W-1:0] POWER_LOAD = DLY_W'(POWER_CYC - 1);
  localparam logic [DLY_W-1:0] CLEAR_LOAD = DLY_W'(CLEAR_CYC);

  state_e           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       mode_sel_q, mode_sel_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;
  logic             xfer, end_step, e_win, rewrite_req, enter_line1;

  assign xfer = is_xfer(state_q);

  lcd_step_timer #(.STEP_CYC(STEP_CYC)) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (xfer),
    .end_step (end_step),
    .e_win    (e_win)
  );

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    rewrite_req = refresh || (mode != mode_sel_q);
    case (state_q)
      // Counter comes out of reset at zero, so the first DELAY cycle loads it.
      ST_DELAY: begin
        if ((dly_q == DLY_ONE) || ((dly_q == '0) && (POWER_CYC <= 1))) begin
          state_d = ST_FUNC_SET;
          dly_d   = '0;
        end else if (dly_q == '0) begin
          dly_d = POWER_LOAD;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      ST_FUNC_SET: if (end_step) state_d = ST_DISP_ON;
      ST_DISP_ON:  if (end_step) state_d = ST_ENTRY;
      ST_ENTRY:    if (end_step) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (end_step) begin
          state_d = (CLEAR_CYC == 0) ? ST_LINE1 : ST_CLR_WAIT;
          dly_d   = CLEAR_LOAD;
        end
      end
      ST_CLR_WAIT: begin
        if (dly_q <= DLY_ONE) begin
          state_d = ST_LINE1;
          dly_d   = '0;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      ST_LINE1: if (end_step) state_d = ST_WRITE;
      ST_WRITE: begin
        if (end_step && (cnt_q == 4'd15))
          state_d = (pending_q || rewrite_req) ? ST_LINE1 : ST_IDLE;
      end
      ST_IDLE:  if (rewrite_req) state_d = ST_LINE1;
      default:  state_d = ST_DELAY;
    endcase

    enter_line1 = (state_d == ST_LINE1) && (state_q != ST_LINE1);
    mode_sel_d  = enter_line1 ? mode : mode_sel_q;

    pending_d = pending_q;
    if (enter_line1)
      pending_d = 1'b0;
    else if (((state_q == ST_LINE1) || (state_q == ST_WRITE)) && rewrite_req)
      pending_d = 1'b1;

    cnt_d = '0;
    if ((state_q == ST_WRITE) && (state_d == ST_WRITE))
      cnt_d = end_step ? cnt_q + 4'd1 : cnt_q;

    done_d = (state_d == ST_IDLE) && (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_DELAY;
      dly_q      <= '0;
      cnt_q      <= '0;
      mode_sel_q <= MODE_WATCH;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      cnt_q      <= cnt_d;
      mode_sel_q <= mode_sel_d;
      pending_q  <= pending_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    lcd_db = 8'h00;
    if (state_q == ST_WRITE) lcd_db = char_data;
    else if (xfer)           lcd_db = cmd_byte(state_q);
  end

  assign lcd_e    = e_win;
  assign lcd_rs   = (state_q == ST_WRITE);
  assign lcd_rw   = 1'b0;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign cnt      = cnt_q;
  assign mode_sel = mode_sel_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - self-checking bench for lcd_sequencer with a program-position model
module tb_lcd_sequencer;

  localparam int S_CYC    = 4;
  localparam int P_CYC    = 10;
  localparam int C_CYC    = 8;
  localparam int INIT_LEN = P_CYC + 4 * S_CYC + C_CYC;
  localparam int LINE_LEN = 17 * S_CYC;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       refresh;
  logic [7:0] char_data;
  logic [1:0] mode_sel;
  logic [3:0] cnt;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;
  logic       busy, done;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  always #5 clk = ~clk;

  function automatic logic [7:0] lut(logic [1:0] ms, int c);
    return 8'(64 + int'(ms) * 16 + c);
  endfunction

  assign char_data = lut(mode_sel, int'(cnt));

  lcd_sequencer #(.STEP_CYC(S_CYC), .POWER_CYC(P_CYC), .CLEAR_CYC(C_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .refresh   (refresh),
    .char_data (char_data),
    .mode_sel  (mode_sel),
    .cnt       (cnt),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_db    (lcd_db),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = init program, 1 = line program, 2 = idle; m_pos = cycle within program.
  int         m_phase = 0;
  int         m_pos   = 0;
  logic [1:0] m_msel  = 2'b00;
  bit         m_pend  = 1'b0;
  bit         m_done  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0; m_pos <= 0; m_msel <= 2'b00; m_pend <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (m_phase)
        0: begin
          if (m_pos == INIT_LEN - 1) begin
            m_phase <= 1; m_pos <= 0; m_msel <= mode; m_pend <= 1'b0;
          end else m_pos <= m_pos + 1;
        end
        1: begin
          if (m_pos == LINE_LEN - 1) begin
            if (m_pend || refresh || (mode != m_msel)) begin
              m_pos <= 0; m_msel <= mode; m_pend <= 1'b0;
            end else begin
              m_phase <= 2; m_pos <= 0; m_done <= 1'b1;
            end
          end else begin
            m_pos <= m_pos + 1;
            if (refresh || (mode != m_msel)) m_pend <= 1'b1;
          end
        end
        default: begin
          if (refresh || (mode != m_msel)) begin
            m_phase <= 1; m_pos <= 0; m_msel <= mode;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    int idx, s;
    logic xe, xrs;
    logic [7:0] xdb;
    logic [3:0] xcnt;
    xe = 1'b0; xrs = 1'b0; xdb = 8'h00; xcnt = 4'd0; idx = 0; s = 0;
    if (m_phase == 0 && m_pos >= P_CYC && m_pos < P_CYC + 4 * S_CYC) begin
      idx = (m_pos - P_CYC) / S_CYC;
      s   = (m_pos - P_CYC) % S_CYC;
      xe  = (s >= 1) && (s <= S_CYC / 2);
      xdb = init_cmds[idx];
    end else if (m_phase == 1) begin
      idx = m_pos / S_CYC;
      s   = m_pos % S_CYC;
      xe  = (s >= 1) && (s <= S_CYC / 2);
      if (idx == 0) xdb = 8'h80;
      else begin
        xrs = 1'b1; xcnt = 4'(idx - 1); xdb = lut(m_msel, idx - 1);
      end
    end
    chk("lcd_e", lcd_e, xe);
    chk("lcd_rs", lcd_rs, xrs);
    chk("lcd_rw", lcd_rw, 0);
    chk("lcd_db", lcd_db, xdb);
    chk("cnt", cnt, xcnt);
    chk("mode_sel", mode_sel, m_msel);
    chk("busy", busy, (m_phase != 2) ? 1 : 0);
    chk("done", done, m_done);
  end

  // Runs until the first done pulse; cycle 1 is the first cycle after the driving cycle.
  task automatic run_line(input int bound, input bit mid_change, input logic [1:0] new_mode,
                          output int done_at, output int e_hi, output int init_seen,
                          output logic [1:0] msel_mid, output logic [1:0] msel_done);
    bit changed = 1'b0;
    bit got_mid = 1'b0;
    done_at = -1; e_hi = 0; init_seen = 0; msel_mid = 2'b00; msel_done = 2'b00;
    for (int i = 1; i <= bound && done_at < 0; i++) begin
      @(negedge clk);
      if (done) begin done_at = i; msel_done = mode_sel; end
      if (lcd_e) e_hi++;
      if (lcd_e && !lcd_rs && (lcd_db == 8'h38 || lcd_db == 8'h0C || lcd_db == 8'h06 || lcd_db == 8'h01))
        init_seen++;
      if (!got_mid && lcd_rs && cnt == 4'd12) begin msel_mid = mode_sel; got_mid = 1'b1; end
      #1;
      refresh = 1'b0;
      if (mid_change && !changed && lcd_rs && cnt == 4'd5) begin mode = new_mode; changed = 1'b1; end
    end
    @(negedge clk);
    chk("done_width", done, 0);
  endtask

  initial begin
    int d, e, ini;
    logic [1:0] mm, md;
    rst = 1'b0; mode = 2'b00; refresh = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1);
    chk("reset_done", done, 0);
    chk("reset_db", lcd_db, 8'h00);
    #1 rst = 1'b1;

    run_line(300, 1'b0, 2'b00, d, e, ini, mm, md);
    chk("init_done_cycle", d, 102);
    chk("init_e_cycles", e, 42);
    chk("init_cmd_strobes", ini, 8);
    chk("init_msel", md, 2'b00);

    repeat (3) @(negedge clk);
    #1 mode = 2'b10;
    run_line(200, 1'b0, 2'b00, d, e, ini, mm, md);
    chk("mode10_done_cycle", d, 69);
    chk("mode10_e_cycles", e, 34);
    chk("mode10_no_init", ini, 0);
    chk("mode10_msel", md, 2'b10);

    #1 mode = 2'b00;
    run_line(200, 1'b0, 2'b00, d, e, ini, mm, md);
    chk("mode00_done_cycle", d, 69);

    repeat (2) @(negedge clk);
    #1 refresh = 1'b1;
    run_line(300, 1'b1, 2'b01, d, e, ini, mm, md);
    chk("midchg_done_cycle", d, 137);
    chk("midchg_e_cycles", e, 68);
    chk("midchg_msel_first", mm, 2'b00);
    chk("midchg_msel_done", md, 2'b01);

    repeat (2) @(negedge clk);
    #1 begin refresh = 1'b1; mode = 2'b11; end
    run_line(200, 1'b0, 2'b00, d, e, ini, mm, md);
    chk("both_done_cycle", d, 69);
    chk("both_e_cycles", e, 34);
    repeat (5) @(negedge clk);
    chk("both_idle_busy", busy, 0);

    #1 rst = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("funcset_s2_e", lcd_e, 1);
    chk("funcset_s2_db", lcd_db, 8'h38);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_e", lcd_e, 0);
    chk("async_rst_db", lcd_db, 8'h00);
    chk("async_rst_busy", busy, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    run_line(300, 1'b0, 2'b00, d, e, ini, mm, md);
    chk("rerun_done_cycle", d, 102);
    chk("rerun_cmd_strobes", ini, 8);
    chk("rerun_msel", md, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
